matmul_host_io: RTL and testbench

Host-side streaming front end for the 8x8 signed matrix-multiply engine. It accepts a word stream with a valid/ready handshake and writes the first matrix into the X memory, row-major, then the second into the Y memory. It then pulses the engine's start input, waits for done, and reads the Z result memory back out as a valid/ready stream. It owns the write ports of X/Y, the read port of Z, and the start/done handshake; the engine owns the opposite ports.

---
 rtl/matmul_host_io.sv | 160 ++++++++++++++++
 tb/tb_matmul_host_io.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_host_io.sv
// matmul_host_io
// Host-side streaming front end for the 8x8 matrix-multiply engine.
// It loads X and then Y from an input stream, starts the engine, waits for done,
// and then streams the Z result memory back out. It does no arithmetic on the data.
module matmul_host_io #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MATRIX_DIM = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  // input stream
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  // X memory write port
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic                  x_wr_en,
  // Y memory write port
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  y_wr_en,
  // engine handshake
  output logic                  mm_start,
  input  logic                  mm_done,
  // Z memory read port (one-cycle read latency)
  output logic [ADDR_WIDTH-1:0] z_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  // output stream
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned           NWORDS = MATRIX_DIM * MATRIX_DIM;
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_LOAD_X,
    S_LOAD_Y,
    S_START,
    S_WAIT,
    S_RD,
    S_CAP,
    S_OUT
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_wait_first;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_valid;

  logic                    w_loading;
  logic                    w_accept;
  logic                    w_last;

  // Input is accepted only while loading; reset forces in_ready low immediately
  // so a beat presented during reset is never written.
  assign w_loading = (r_state == S_LOAD_X) || (r_state == S_LOAD_Y);
  assign in_ready  = w_loading && !reset;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == LAST);

  // Memory write ports are driven combinationally from the accepted beat;
  // address and data are forced to zero whenever the enable is low.
  assign x_wr_en = w_accept && (r_state == S_LOAD_X);
  assign x_addr  = x_wr_en ? r_cnt : '0;
  assign x_din   = x_wr_en ? in_data : '0;

  assign y_wr_en = w_accept && (r_state == S_LOAD_Y);
  assign y_addr  = y_wr_en ? r_cnt : '0;
  assign y_din   = y_wr_en ? in_data : '0;

  // START lasts exactly one cycle, so decoding it from the state register
  // gives a clean single-cycle pulse.
  assign mm_start = (r_state == S_START);
  assign z_addr   = (r_state == S_RD) ? r_cnt : '0;

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // Idle means waiting for the first X word of a new run.
  assign busy = !((r_state == S_LOAD_X) && (r_cnt == '0));

  // Control FSM: load X, load Y, start, wait for done, then read/capture/emit each Z word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD_X;
      r_cnt        <= '0;
      r_wait_first <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD_X: begin
          if (w_accept) begin
            if (w_last) begin
              r_state <= S_LOAD_Y;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_LOAD_Y: begin
          if (w_accept) begin
            if (w_last) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_START: begin
          r_state      <= S_WAIT;
          r_wait_first <= 1'b1;
        end
        S_WAIT: begin
          // The engine still shows the previous run's done during the first
          // WAIT cycle, so that cycle never advances.
          if (r_wait_first) begin
            r_wait_first <= 1'b0;
          end else if (mm_done) begin
            r_state <= S_RD;
            r_cnt   <= '0;
          end
        end
        S_RD: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          r_out_data  <= z_dout;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_X;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_RD;
            end
          end
        end
        default: begin
          r_state <= S_LOAD_X;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_host_io.sv
// Testbench for matmul_host_io: bench-side X/Y/Z memories and engine model,
// directed runs with random and structured matrices, expected results from a
// plain matrix-product reference.
module tb_matmul_host_io;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int N  = 8;
  localparam int NN = N * N;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x_din, y_din;
  logic [AW-1:0] x_addr, y_addr, z_addr;
  logic          x_wr_en, y_wr_en, mm_start;
  logic          mm_done;
  logic [DW-1:0] z_dout = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] xs[NN];
  logic [DW-1:0] ys[NN];
  logic [DW-1:0] zexp[NN];

  // engine model state
  logic [DW-1:0] x_mem[NN];
  logic [DW-1:0] y_mem[NN];
  logic [DW-1:0] z_mem[NN];
  int            eng_cnt = 0;
  logic          hold_done = 1'b0;
  logic          done_q = 1'b0;

  assign mm_done = done_q;

  matmul_host_io #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MATRIX_DIM(N)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_din    (x_din),
    .x_addr   (x_addr),
    .x_wr_en  (x_wr_en),
    .y_din    (y_din),
    .y_addr   (y_addr),
    .y_wr_en  (y_wr_en),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .z_addr   (z_addr),
    .z_dout   (z_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Memories plus engine: computes Z on start, drops done one cycle later,
  // raises done a few cycles after that (unless hold_done keeps it high).
  always @(posedge clock) begin
    if (x_wr_en) x_mem[x_addr[5:0]] <= x_din;
    if (y_wr_en) y_mem[y_addr[5:0]] <= y_din;
    z_dout <= z_mem[z_addr[5:0]];
    if (mm_start) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          int acc;
          acc = 0;
          for (int k = 0; k < N; k++) acc += int'(x_mem[r*N+k]) * int'(y_mem[k*N+c]);
          z_mem[r*N+c] <= DW'(acc);
        end
      end
      eng_cnt <= 5;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end
    if (eng_cnt == 5) done_q <= hold_done;
    else if (eng_cnt == 1) done_q <= 1'b1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: Z = X * Y with 32-bit wrapping signed arithmetic.
  function automatic void ref_mm();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) acc += int'(xs[r*N+k]) * int'(ys[k*N+c]);
        zexp[r*N+c] = DW'(acc);
      end
    end
  endfunction

  task automatic load_mat(input bit is_y, input bit gaps, input int count);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = $urandom;
        #1;
        chk("gap_no_write",
            128'({x_wr_en, y_wr_en, x_addr, y_addr, x_din, y_din, in_ready, busy}),
            128'({2'b00, AW'(0), AW'(0), DW'(0), DW'(0), 1'b1, (is_y || i != 0)}));
      end
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = is_y ? ys[i] : xs[i];
      #1;
      if (!is_y)
        chk("x_beat",
            128'({x_wr_en, x_addr, x_din, y_wr_en, mm_start, in_ready, busy}),
            128'({1'b1, AW'(i), xs[i], 1'b0, 1'b0, 1'b1, (i != 0)}));
      else
        chk("y_beat",
            128'({y_wr_en, y_addr, y_din, x_wr_en, mm_start, in_ready, busy}),
            128'({1'b1, AW'(i), ys[i], 1'b0, 1'b0, 1'b1, 1'b1}));
    end
  endtask

  task automatic read_results(input int bp_word, input int exp_cycles);
    int w;
    int guard;
    int held;
    w = 0;
    guard = 0;
    held = 0;
    while (w < NN && guard < 3000) begin
      @(negedge clock);
      #1;
      guard++;
      if (out_valid) begin
        if (w == bp_word && held < 5) begin
          chk("bp_hold", 128'({out_valid, out_data, z_addr, busy}),
              128'({1'b1, zexp[w], AW'(0), 1'b1}));
          out_ready = 1'b0;
          held++;
        end else begin
          chk("out_word", 128'({out_data, busy, in_ready}), 128'({zexp[w], 1'b1, 1'b0}));
          out_ready = 1'b1;
          w++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    chk("words_read", 128'(w), 128'(NN));
    if (exp_cycles >= 0) chk("read_cycles", 128'(guard), 128'(exp_cycles));
  endtask

  task automatic do_run(input bit gaps, input bit stale, input int bp_word, input int exp_cycles);
    ref_mm();
    load_mat(1'b0, gaps, NN);
    load_mat(1'b1, gaps, NN);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = $urandom;
    #1;
    chk("start_pulse", 128'({mm_start, in_ready, x_wr_en, y_wr_en, busy}), 128'(5'b10001));
    if (stale) begin
      for (int k = 1; k <= 5; k++) begin
        @(negedge clock);
        #1;
        chk("stale_wait", 128'({out_valid, in_ready, mm_start, x_wr_en, y_wr_en}),
            128'({(k == 5), 4'b0000}));
      end
    end
    in_valid = 1'b0;
    read_results(bp_word, exp_cycles);
    @(negedge clock);
    #1;
    out_ready = 1'b0;
    chk("idle_after_run", 128'({busy, in_ready, out_valid}), 128'(3'b010));
  endtask

  initial begin
    #2 reset = 1'b1;
    @(negedge clock);
    #1;
    chk("reset_ctrl", 128'({in_ready, x_wr_en, y_wr_en, mm_start, out_valid, busy}), 128'(6'b0));
    chk("reset_data", 128'({x_addr, y_addr, z_addr, x_din, y_din, out_data}), 128'(0));
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_reset", 128'({in_ready, busy, out_valid, mm_start}), 128'(4'b1000));

    // Run 1: identity X, Y = 0..63, no gaps, no backpressure
    for (int i = 0; i < NN; i++) begin
      xs[i] = (i / N == i % N) ? DW'(1) : DW'(0);
      ys[i] = DW'(i);
    end
    do_run(1'b0, 1'b0, -1, 198);

    // Run 2: random data, input gaps, stale done, backpressure on word 10
    for (int i = 0; i < NN; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
    end
    hold_done = 1'b1;
    do_run(1'b1, 1'b1, 10, -1);
    hold_done = 1'b0;

    // Reset in the middle of the Y load
    for (int i = 0; i < NN; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
    end
    load_mat(1'b0, 1'b0, NN);
    load_mat(1'b1, 1'b0, 20);
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    #1;
    chk("midreset_ctrl", 128'({in_ready, x_wr_en, y_wr_en, mm_start, out_valid, busy}), 128'(6'b0));
    chk("midreset_data", 128'({x_addr, y_addr, z_addr, x_din, y_din, out_data}), 128'(0));
    @(negedge clock);
    #1;
    chk("midreset_hold", 128'({in_ready, y_wr_en, x_wr_en, busy}), 128'(4'b0));
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midreset_release", 128'({in_ready, busy, x_wr_en, y_wr_en}), 128'(4'b1000));

    // Runs 4 and 5 back to back with negated Y values
    for (int i = 0; i < NN; i++) begin
      xs[i] = $urandom_range(0, 200) - 100;
      ys[i] = DW'(-i);
    end
    do_run(1'b0, 1'b0, -1, 198);
    for (int i = 0; i < NN; i++) begin
      xs[i] = $urandom;
      ys[i] = DW'(-int'($urandom_range(1, 100000)));
    end
    do_run(1'b0, 1'b0, -1, 198);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
